// File: rtl/uart_rx_fifo_if.sv
// CPU-side bus of the UART receiver: pop/clear strobes in, FIFO head and flags out.
// The CPU glue is the master, the receiver is the slave.
`timescale 1ns/1ps
interface uart_rx_fifo_if;
   logic       i_pop;
   logic       i_clr_err;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_overrun;

   modport master (
      output i_pop,
      output i_clr_err,
      input  o_data,
      input  o_valid,
      input  o_frame_err,
      input  o_overrun
   );

   modport slave (
      input  i_pop,
      input  i_clr_err,
      output o_data,
      output o_valid,
      output o_frame_err,
      output o_overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small circular receive FIFO and sticky
// frame-error / overrun flags. All line sampling is mid-bit on synced rxd.
`timescale 1ns/1ps
module uart_rx_fifo #(
   parameter int CLK_FREQ_HZ = 10_000_000,
   parameter int BAUD_RATE   = 1_000_000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          rxd,
   uart_rx_fifo_if.slave bus
);
   localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
   localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } state_t;

   state_t        state;
   state_t        state_nx;

   logic          rx_m;
   logic          rx_s;
   logic [CW-1:0] cnt;
   logic          cnt_zero;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   logic          ld_half;
   logic          ld_full;
   logic          dec;
   logic          shift;
   logic          clr_idx;
   logic          push;
   logic          set_fe;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          do_pop;
   logic          do_wr;
   logic          set_ovr;

   logic          frame_err;
   logic          overrun;

   assign cnt_zero = (cnt == '0);
   assign full     = (count == DEPTH_C);
   assign do_pop   = bus.i_pop & (count != '0);
   // A full FIFO still takes the byte when the head is popped in the same cycle.
   assign do_wr    = push & (~full | do_pop);
   assign set_ovr  = push & full & ~do_pop;

   assign bus.o_data      = mem[rd_ptr];
   assign bus.o_valid     = (count != '0);
   assign bus.o_frame_err = frame_err;
   assign bus.o_overrun   = overrun;

   // Two-flop synchronizer for the asynchronous line; idles high.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rxd;
         rx_s <= rx_m;
      end
   end

   // Receiver state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Frame sequencing: start check, eight data bits, stop check, break wait.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (!rx_s) state_nx = START;
         end
         START: begin
            if (cnt_zero) state_nx = rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (cnt_zero && bit_idx == 3'd7) state_nx = STOP;
         end
         STOP: begin
            if (cnt_zero) state_nx = rx_s ? IDLE : BRK;
         end
         BRK: begin
            if (rx_s) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Per-state datapath controls: counter loads, shifting, push and error.
   always_comb begin
      ld_half = 1'b0;
      ld_full = 1'b0;
      dec     = 1'b0;
      shift   = 1'b0;
      clr_idx = 1'b0;
      push    = 1'b0;
      set_fe  = 1'b0;
      unique case (state)
         IDLE: begin
            ld_half = ~rx_s;
         end
         START: begin
            dec     = ~cnt_zero;
            ld_full = cnt_zero & ~rx_s;
            clr_idx = cnt_zero;
         end
         DATA: begin
            dec     = ~cnt_zero;
            ld_full = cnt_zero;
            shift   = cnt_zero;
         end
         STOP: begin
            dec     = ~cnt_zero;
            push    = cnt_zero & rx_s;
            set_fe  = cnt_zero & ~rx_s;
         end
         BRK: begin
         end
         default: begin
         end
      endcase
   end

   // Bit-time counter, bit index and LSB-first shift register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         if (ld_half) begin
            cnt <= CNT_HALF;
         end else if (ld_full) begin
            cnt <= CNT_FULL;
         end else if (dec) begin
            cnt <= cnt - CW'(1);
         end
         if (clr_idx) begin
            bit_idx <= '0;
         end else if (shift) begin
            bit_idx <= bit_idx + 3'd1;
         end
         if (shift) begin
            shreg <= {rx_s, shreg[7:1]};
         end
      end
   end

   // Receive FIFO: storage, wrapping pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({do_wr, do_pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a new error beats a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (set_fe) begin
            frame_err <= 1'b1;
         end else if (bus.i_clr_err) begin
            frame_err <= 1'b0;
         end
         if (set_ovr) begin
            overrun <= 1'b1;
         end else if (bus.i_clr_err) begin
            overrun <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial stimulus, queue model of received bytes,
// monitor that pops and scores the FIFO head.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
   localparam int DIV   = 10;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic resetn;
   logic rxd;
   logic clr;
   logic mon_pop;
   logic drain;
   logic force_pop;

   logic [7:0] exp_q[$];
   logic       exp_fe;
   logic       exp_ovr;

   int tests = 0;
   int fails = 0;

   uart_rx_fifo_if bus ();

   assign bus.i_pop     = mon_pop;
   assign bus.i_clr_err = clr;

   uart_rx_fifo #(
      .CLK_FREQ_HZ(10_000_000),
      .BAUD_RATE  (1_000_000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .rxd   (rxd),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops whenever draining (or on a scheduled pop) and scores the head.
   initial begin
      mon_pop = 1'b0;
      forever begin
         @(negedge clk);
         mon_pop = 1'b0;
         if (resetn === 1'b1 && bus.o_valid === 1'b1 && (drain || force_pop)) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_byte: got %02h expected none", bus.o_data);
            end else begin
               check("rx_byte", {24'd0, bus.o_data}, {24'd0, exp_q.pop_front()});
            end
            mon_pop = 1'b1;
         end
      end
   end

   initial begin
      #400_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // One 8N1 frame starting at the next edge; leaves rxd at the stop level.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         rxd = f[i];
         repeat (DIV) @(posedge clk);
         #1;
      end
   endtask

   // Frame plus reference-model update: good bytes queue unless four are held.
   task automatic xmit(input logic [7:0] b, input logic good, input int gap);
      int g;
      g = gap;
      if (good) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else exp_ovr = 1'b1;
      end else begin
         exp_fe = 1'b1;
         if (g < 4) g = 4;
      end
      send_frame(b, good);
      rxd = 1'b1;
      repeat (g) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      drain = 1'b1;
      while ((exp_q.size() != 0 || bus.o_valid !== 1'b0) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      drain = 1'b0;
      check({name, "_left"}, exp_q.size(), 0);
      check({name, "_valid"}, {31'd0, bus.o_valid}, 0);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   task automatic check_flags(input string name);
      check({name, "_fe"}, {31'd0, bus.o_frame_err}, {31'd0, exp_fe});
      check({name, "_ovr"}, {31'd0, bus.o_overrun}, {31'd0, exp_ovr});
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] b5;
      logic       good;
      resetn    = 1'b0;
      rxd       = 1'b1;
      clr       = 1'b0;
      drain     = 1'b0;
      force_pop = 1'b0;
      exp_fe    = 1'b0;
      exp_ovr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, bus.o_valid}, 0);
      check("rst_data", {24'd0, bus.o_data}, 0);
      check_flags("rst");
      resetn = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // Two back-to-back bytes, then pop both.
      xmit(8'hA5, 1'b1, 0);
      xmit(8'h3C, 1'b1, 2);
      check("t1_valid", {31'd0, bus.o_valid}, 1);
      check("t1_head", {24'd0, bus.o_data}, 32'hA5);
      wait_drain("t1");

      // Five bytes with no pop: the fifth is dropped.
      for (int i = 1; i <= 5; i++) xmit(8'(i), 1'b1, 1);
      check_flags("t2");
      check("t2_head", {24'd0, bus.o_data}, 32'h01);
      wait_drain("t2");
      pulse_clr();
      exp_ovr = 1'b0;
      check_flags("t2_clr");

      // Full FIFO with a pop landing in the push cycle.
      for (int i = 0; i < 4; i++) xmit(8'($urandom), 1'b1, 2);
      b5 = 8'($urandom);
      exp_q.push_back(b5);
      fork
         send_frame(b5, 1'b1);
         begin
            repeat (98) @(posedge clk);
            #1;
            force_pop = 1'b1;
            @(posedge clk);
            #1;
            force_pop = 1'b0;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      check_flags("t3");
      check("t3_left", exp_q.size(), 4);
      check("t3_head", {24'd0, bus.o_data}, {24'd0, exp_q[0]});
      wait_drain("t3");

      // Stop bit low, line held low: one error only, then clean reception.
      exp_fe = 1'b1;
      send_frame(8'h55, 1'b0);
      check("t4_fe", {31'd0, bus.o_frame_err}, 1);
      check("t4_valid", {31'd0, bus.o_valid}, 0);
      repeat (20) @(posedge clk);
      #1;
      pulse_clr();
      exp_fe = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      rxd = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check_flags("t4_single");
      check("t4_nobyte", {31'd0, bus.o_valid}, 0);
      xmit(8'h55, 1'b1, 3);
      wait_drain("t4_next");
      check_flags("t4_next");

      // Clear strobe coinciding with a stop-bit error: the error survives.
      fork
         send_frame(8'hC3, 1'b0);
         begin
            repeat (98) @(posedge clk);
            #1;
            clr = 1'b1;
            @(posedge clk);
            #1;
            clr = 1'b0;
         end
      join
      exp_fe = 1'b1;
      rxd = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check_flags("t4b");
      pulse_clr();
      exp_fe = 1'b0;
      check_flags("t4b_clr");

      // Short low glitch on an idle line.
      rxd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rxd = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("t5_valid", {31'd0, bus.o_valid}, 0);
      check_flags("t5");
      xmit(8'h6E, 1'b1, 2);
      wait_drain("t5_next");

      // Random bytes, gaps and occasional bad stop bits, drained live.
      drain = 1'b1;
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom);
         good = ($urandom_range(0, 4) != 0);
         xmit(b, good, int'($urandom_range(0, 12)));
      end
      wait_drain("rand");
      check_flags("rand");
      pulse_clr();
      exp_fe = 1'b0;

      // Reset in the middle of bit 4 with data and an error pending.
      xmit(8'h42, 1'b1, 3);
      xmit(8'h00, 1'b0, 4);
      check("t6_pre_valid", {31'd0, bus.o_valid}, 1);
      b = 8'h81;
      @(posedge clk);
      #1;
      rxd = 1'b0;
      repeat (DIV) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         rxd = b[i];
         repeat (DIV) @(posedge clk);
         #1;
      end
      rxd = b[4];
      repeat (DIV / 2) @(posedge clk);
      #1;
      resetn = 1'b0;
      rxd = 1'b1;
      exp_q.delete();
      exp_fe = 1'b0;
      exp_ovr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("t6_valid", {31'd0, bus.o_valid}, 0);
      check("t6_data", {24'd0, bus.o_data}, 0);
      check_flags("t6");
      resetn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      xmit(8'h81, 1'b1, 3);
      check("t6_head", {24'd0, bus.o_data}, 32'h81);
      wait_drain("t6");
      check_flags("t6_end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
